// File: rtl/sseg_mux_decoder.sv
// Readback decoder for a multiplexed active-low seven-segment bus: recovers per-digit nibble/DP
// once the bus has been stable. Define SSEG_DECODER_BLANK_EN to accept 7F as a legal blank digit.
module sseg_mux_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_DIGITS-1:0]           an,
  input  logic [7:0]                      sseg,
  output logic [4*NUM_DIGITS-1:0]         hex_out,
  output logic [NUM_DIGITS-1:0]           dp_out,
  output logic [NUM_DIGITS-1:0]           digit_valid,
  output logic [NUM_DIGITS-1:0]           digit_err,
  output logic                            upd_stb,
  output logic [$clog2(NUM_DIGITS)-1:0]   upd_idx
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_seg;
  logic [CW-1:0]         cnt;
  logic                  armed;

  logic [NUM_DIGITS-1:0] an_act;
  logic                  one_hot;
  logic                  stable;
  logic                  capture;
  logic [IW-1:0]         idx;
  logic [3:0]            nib;
  logic                  legal;
  logic                  blank;

  assign an_act  = ~r_an;
  assign one_hot = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
  // The incoming bus is compared with the registered copy, so a held value counts from the
  // first edge after it appears and the capture lands on edge STABLE_CYCLES+1.
  assign stable  = ({an, sseg} == {r_an, r_seg}) && one_hot;
  assign capture = stable && armed && (cnt == CNT_MAX - CW'(1));

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!r_an[i]) idx = IW'(i);
  end

  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    blank = 1'b0;
    case (r_seg[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
`ifdef SSEG_DECODER_BLANK_EN
      7'h7F: begin
        legal = 1'b0;
        blank = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an        <= '1;
      r_seg       <= '1;
      cnt         <= '0;
      armed       <= 1'b1;
      hex_out     <= '0;
      dp_out      <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      upd_stb     <= 1'b0;
      upd_idx     <= '0;
    end else begin
      r_an    <= an;
      r_seg   <= sseg;
      upd_stb <= capture;
      if (!stable) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (capture) begin
        armed              <= 1'b0;
        hex_out[4*idx +: 4] <= nib;
        dp_out[idx]        <= r_seg[7];
        digit_valid[idx]   <= legal;
        digit_err[idx]     <= !legal && !blank;
        upd_idx            <= idx;
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Scoreboard bench for sseg_mux_decoder: a run-length reference model predicts captures,
// a negedge monitor matches them against upd_stb and the full output vectors.
module tb_sseg_mux_decoder;
  localparam int ND = 8;
  localparam int SC = 4;
  localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 0, reset;
  logic [ND-1:0] an;
  logic [7:0] sseg;
  logic [4*ND-1:0] hex_out;
  logic [ND-1:0] dp_out, digit_valid, digit_err;
  logic upd_stb;
  logic [2:0] upd_idx;

  sseg_mux_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .an(an), .sseg(sseg), .hex_out(hex_out), .dp_out(dp_out),
    .digit_valid(digit_valid), .digit_err(digit_err), .upd_stb(upd_stb), .upd_idx(upd_idx));

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int idx;
    logic [31:0] hex;
    logic [7:0] dp, val, err;
  } item_t;

  item_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, n_push = 0, n_pop = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void dec(input logic [6:0] s, output logic [3:0] n, output logic v,
                              output logic e);
    n = 4'h0; v = 1'b0; e = 1'b1;
    for (int j = 0; j < 16; j++)
      if (TBL[j] == s) begin n = 4'(j); v = 1'b1; e = 1'b0; end
`ifdef SSEG_DECODER_BLANK_EN
    if (s == 7'h7F) e = 1'b0;
`endif
  endfunction

  // Reference model: a digit is captured once its bus value has been presented unchanged,
  // with exactly one active anode, on STABLE_CYCLES+1 consecutive non-reset edges.
  logic [15:0] last_in = '1;
  int run = 0;
  logic [31:0] m_hex = 0;
  logic [7:0] m_dp = 0, m_val = 0, m_err = 0;

  always @(posedge clk) begin
    logic [3:0] n; logic v, e; int k; item_t it;
    cyc++;
    if (reset) begin
      last_in = '1; run = 0; m_hex = 0; m_dp = 0; m_val = 0; m_err = 0;
    end else begin
      if ({an, sseg} == last_in && $countones(~an) == 1) run++;
      else run = 0;
      last_in = {an, sseg};
      if (run == SC) begin
        k = 0;
        for (int j = 0; j < ND; j++) if (!an[j]) k = j;
        dec(sseg[6:0], n, v, e);
        m_hex[4*k +: 4] = n; m_dp[k] = sseg[7]; m_val[k] = v; m_err[k] = e;
        it.cyc = cyc; it.idx = k; it.hex = m_hex; it.dp = m_dp; it.val = m_val; it.err = m_err;
        q.push_back(it);
        n_push++;
      end
    end
  end

  logic prev_stb = 0;
  always @(negedge clk) begin
    item_t it;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missing_strobe", 0, 1);
      void'(q.pop_front());
    end
    if (upd_stb) begin
      chk("stb_twice", prev_stb, 0);
      if (q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        it = q.pop_front(); n_pop++;
        chk("upd_idx", upd_idx, it.idx);
        chk("hex_out", hex_out, it.hex);
        chk("dp_out", dp_out, it.dp);
        chk("digit_valid", digit_valid, it.val);
        chk("digit_err", digit_err, it.err);
      end
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("missing_strobe", 0, 1);
      void'(q.pop_front());
    end
    prev_stb = upd_stb;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_hex"}, hex_out, 0);
    chk({nm, "_dp"}, dp_out, 0);
    chk({nm, "_val"}, digit_valid, 0);
    chk({nm, "_err"}, digit_err, 0);
    chk({nm, "_stb"}, upd_stb, 0);
    chk({nm, "_idx"}, upd_idx, 0);
  endtask

  initial begin
    reset = 1; an = 8'hFE; sseg = 8'h40;
    step(3);
    chk_zero("reset");
    reset = 0; an = 8'hFB; sseg = 8'h19;
    step(4);
    chk("basic_early_stb", upd_stb, 0);
    step(1);
    chk("basic_hex2", hex_out[11:8], 4);
    chk("basic_val2", digit_valid[2], 1);
    chk("basic_stb", upd_stb, 1);
    chk("basic_idx", upd_idx, 2);
    step(2);

    an = 8'hFE; sseg = 8'h24; step(3);
    sseg = 8'h30; step(7);
    chk("stab_hex0", hex_out[3:0], 3);
    chk("stab_hex2_kept", hex_out[11:8], 4);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] a;
      a = 8'h01 << k;
      an = ~a; sseg = {(k == 5) ? 1'b0 : 1'b1, TBL[k]};
      step(6);
    end
    chk("scan_hex", hex_out, 32'h76543210);
    chk("scan_dp", dp_out, 8'hDF);
    chk("scan_idx", upd_idx, 7);

    an = 8'hFC; sseg = 8'h40; step(8);
    chk("multi_hex", hex_out, 32'h76543210);
    an = 8'hFD; sseg = 8'hFF; step(6);
`ifdef SSEG_DECODER_BLANK_EN
    chk("blank_err1", digit_err[1], 0);
`else
    chk("illegal_err1", digit_err[1], 1);
`endif
    chk("illegal_val1", digit_valid[1], 0);
    chk("illegal_hex1", hex_out[7:4], 0);

    an = 8'hFE; sseg = 8'h79; step(3);
    reset = 1; step(1);
    chk_zero("midreset");
    reset = 0; step(4);
    chk("midreset_early", upd_stb, 0);
    step(1);
    chk("midreset_stb", upd_stb, 1);
    chk("midreset_hex0", hex_out[3:0], 1);

    for (int s = 0; s < 400; s++) begin
      logic [7:0] a;
      a = 8'h01 << $urandom_range(0, 7);
      an = ($urandom_range(0, 9) < 8) ? ~a : 8'($urandom);
      case ($urandom_range(0, 5))
        0: sseg = 8'($urandom);
        1: sseg = {1'($urandom), 7'h7F};
        default: sseg = {1'($urandom), TBL[$urandom_range(0, 15)]};
      endcase
      reset = ($urandom_range(0, 39) == 0);
      step(1);
      reset = 0;
      step($urandom_range(0, 7));
    end
    step(3);
    chk("queue_drained", q.size(), 0);
    chk("strobe_count", n_pop, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
